// File: rtl/branch_ctrl_pkg.sv
// branch_ctrl_pkg: shared opcodes, FSM state type and decode helper for branch_ctrl.
//   OPC_W      opcode field width (top nibble of the instruction)
//   CNT_W      squash counter width (covers SHADOW = 1..3)
//   OP_*       control-flow opcodes
//   state_e    controller state
//   is_ctrl()  1 for opcodes that alter control flow
package branch_ctrl_pkg;

  localparam int unsigned OPC_W = 4;
  localparam int unsigned CNT_W = 2;

  localparam logic [OPC_W-1:0] OP_BEQ  = 4'hC;
  localparam logic [OPC_W-1:0] OP_BNE  = 4'hD;
  localparam logic [OPC_W-1:0] OP_BRA  = 4'hE;
  localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StSquash,
    StHalted
  } state_e;

  function automatic logic is_ctrl(input logic [OPC_W-1:0] opcode);
    return opcode inside {OP_BEQ, OP_BNE, OP_BRA, OP_HALT};
  endfunction

endpackage

// File: rtl/branch_decode.sv
// branch_decode: combinational classification of the instruction presented by fetch.
//   i_opcode  instruction opcode field
//   i_valid   instruction valid this cycle
//   i_zero    zero flag from execute
//   o_fwd     instruction is to be forwarded to execute (when the FSM is in RUN)
//   o_take    taken branch (BEQ with zero, BNE without zero, BRA)
//   o_halt    HALT opcode
module branch_decode
  import branch_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  input  logic             i_valid,
  input  logic             i_zero,
  output logic             o_fwd,
  output logic             o_take,
  output logic             o_halt
);

  logic w_ctrl;

  assign w_ctrl = is_ctrl(i_opcode);

  always_comb begin
    // Every valid instruction in RUN reaches execute, including branches and HALT.
    o_fwd  = i_valid;
    o_take = 1'b0;
    o_halt = 1'b0;
    if (i_valid && w_ctrl) begin
      unique case (i_opcode)
        OP_BEQ:  o_take = i_zero;
        OP_BNE:  o_take = ~i_zero;
        OP_BRA:  o_take = 1'b1;
        OP_HALT: o_halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: drives fetch control (start / branch) from the returned instruction stream,
// squashes the wrong-path fetch shadow and forwards architecturally valid instructions.
//   clk              clock
//   rst_n            asynchronous active-low reset
//   instr_i          instruction from instruction memory
//   instr_valid_i    instr_i valid
//   zero_i           zero flag from execute, used by BEQ/BNE
//   restart_i        leave HALTED and re-boot
//   start_o          fetch start pulse
//   start_address_o  fetch start address
//   branch_o         fetch branch pulse
//   branchloc_o      relative branch offset (held between branches)
//   instr_o          instruction to execute
//   instr_valid_o    instr_o valid
//   halted_o         core halted
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned           INSTR_W   = 16,
  parameter int unsigned           ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]     BOOT_ADDR = '0,
  parameter int unsigned           SHADOW    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               instr_valid_i,
  input  logic               zero_i,
  input  logic               restart_i,
  output logic               start_o,
  output logic [ADDR_W-1:0]  start_address_o,
  output logic               branch_o,
  output logic [ADDR_W-1:0]  branchloc_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid_o,
  output logic               halted_o
);

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_start;
  logic [ADDR_W-1:0]  r_start_addr;
  logic               r_branch;
  logic [ADDR_W-1:0]  r_branchloc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_instr_valid;
  logic               r_halted;

  logic w_fwd;
  logic w_take;
  logic w_halt;

  branch_decode u_decode (
    .i_opcode (instr_i[INSTR_W-1 -: OPC_W]),
    .i_valid  (instr_valid_i),
    .i_zero   (zero_i),
    .o_fwd    (w_fwd),
    .o_take   (w_take),
    .o_halt   (w_halt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StBoot;
      r_cnt         <= '0;
      r_start       <= 1'b0;
      r_start_addr  <= BOOT_ADDR;
      r_branch      <= 1'b0;
      r_branchloc   <= '0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      // Pulses and the valid strobe default low; state-specific branches raise them.
      r_start       <= 1'b0;
      r_branch      <= 1'b0;
      r_instr_valid <= 1'b0;
      unique case (r_state)
        StBoot: begin
          r_start      <= 1'b1;
          r_start_addr <= BOOT_ADDR;
          // Whatever fetch returns right after a (re)start is stale.
          r_cnt        <= CNT_W'(SHADOW);
          r_state      <= StSquash;
        end
        StRun: begin
          if (w_fwd) begin
            r_instr       <= instr_i;
            r_instr_valid <= 1'b1;
            if (w_halt) begin
              r_halted <= 1'b1;
              r_state  <= StHalted;
            end else if (w_take) begin
              r_branch    <= 1'b1;
              r_branchloc <= instr_i[ADDR_W-1:0];
              r_cnt       <= CNT_W'(SHADOW);
              r_state     <= StSquash;
            end
          end
        end
        StSquash: begin
          // Only real (valid) wrong-path instructions consume the shadow.
          if (instr_valid_i) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt <= CNT_W'(1)) begin
              r_state <= StRun;
            end
          end
        end
        StHalted: begin
          if (restart_i) begin
            r_halted <= 1'b0;
            r_state  <= StBoot;
          end
        end
        default: r_state <= StBoot;
      endcase
    end
  end

  assign start_o         = r_start;
  assign start_address_o = r_start_addr;
  assign branch_o        = r_branch;
  assign branchloc_o     = r_branchloc;
  assign instr_o         = r_instr;
  assign instr_valid_o   = r_instr_valid;
  assign halted_o        = r_halted;

endmodule
